// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result stage behind the ALU and the barrel shifter.
// It selects the ALU, shifter or HI/LO value into a single registered dataOut.
// It also holds a multicycle unsigned shift-add multiplier that writes the HI/LO pair.
// Optional build macro MUL_EARLY_TERM_EN: the multiply finishes as soon as the
// remaining multiplier bits are all zero. Products are the same; only the latency changes.
module alu_result_stage #(
    parameter int         WIDTH   = 32,
    parameter logic [5:0] SRL     = 6'b000010,
    parameter logic [5:0] MULTU   = 6'b011001,
    parameter logic [5:0] MFHI    = 6'b010000,
    parameter logic [5:0] MFLO    = 6'b010010,
    parameter logic [5:0] ALU_ADD = 6'b100000,
    parameter logic [5:0] ALU_SUB = 6'b100010,
    parameter logic [5:0] ALU_AND = 6'b100100,
    parameter logic [5:0] ALU_OR  = 6'b100101,
    parameter logic [5:0] ALU_SLT = 6'b101010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [WIDTH-1:0] aluOut,
    input  logic [WIDTH-1:0] shiftOut,
    output logic             op_ready,
    output logic             busy,
    output logic [WIDTH-1:0] dataOut,
    output logic             out_valid,
    output logic             mul_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [WIDTH-1:0]       hi;
    logic [WIDTH-1:0]       lo;
    logic [2*WIDTH-1:0]     product;
    logic [2*WIDTH-1:0]     product_nxt;
    logic [2*WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]       mplier;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_nxt;
    logic                   mul_last;

    // Result mux for single-cycle ops; codes the stage does not know about yield zero.
    function automatic logic [WIDTH-1:0] select_result(
        input logic [5:0]       code,
        input logic [WIDTH-1:0] alu_val,
        input logic [WIDTH-1:0] shift_val,
        input logic [WIDTH-1:0] hi_val,
        input logic [WIDTH-1:0] lo_val
    );
        logic [WIDTH-1:0] res;
        res = '0;
        case (code)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: res = alu_val;
            SRL:                                        res = shift_val;
            MFHI:                                       res = hi_val;
            MFLO:                                       res = lo_val;
            default:                                    res = '0;
        endcase
        return res;
    endfunction

    // The multiplier is busy exactly while the FSM sits in MUL, so no extra flop is needed.
    assign busy     = (state == MUL);
    assign op_ready = ~busy;

    // One shift-add iteration, plus detection of the final iteration.
    always_comb begin
        product_nxt = product + (mplier[0] ? mcand : '0);
        count_nxt   = count + CNT_W'(1);
`ifdef MUL_EARLY_TERM_EN
        mul_last    = ((mplier >> 1) == '0);
`else
        mul_last    = (count_nxt == CNT_LAST);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: enter MUL on an accepted MULTU, leave on the last iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (op_valid && (Signal == MULTU)) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result register, multiplier datapath and HI/LO. Ops arriving while busy are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut   <= '0;
            out_valid <= 1'b0;
            mul_done  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
        end else begin
            out_valid <= 1'b0;
            mul_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (Signal == MULTU) begin
                            mcand   <= {{WIDTH{1'b0}}, dataA};
                            mplier  <= dataB;
                            product <= '0;
                            count   <= '0;
                        end else begin
                            dataOut   <= select_result(Signal, aluOut, shiftOut, hi, lo);
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    product <= product_nxt;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    count   <= count_nxt;
                    if (mul_last) begin
                        hi       <= product_nxt[2*WIDTH-1:WIDTH];
                        lo       <= product_nxt[WIDTH-1:0];
                        mul_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered result stage directly downstream of the ALU and the barrel shifter.
- Consumes the ALU result and the shifter's dataOut.
- Contains the multicycle unsigned shift-add multiplier and the HI/LO register pair.
- Produces the single registered ALU-unit result for the datapath.
- Selection uses the same 6-bit function code (Signal) that drives the shifter.

Parameters:
- WIDTH, 32: operand/result width. HI and LO are each WIDTH bits.
- SRL, 6'b000010: select shiftOut.
- MULTU, 6'b011001: start multiply.
- MFHI, 6'b010000: output HI.
- MFLO, 6'b010010: output LO.
- ALU codes, 6'b100000/100010/100100/100101/101010 (ADD/SUB/AND/OR/SLT): select aluOut.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  Signal/operands valid this cycle.
- Signal  in  6  function code.
- dataA  in  WIDTH  multiplicand for MULTU.
- dataB  in  WIDTH  multiplier for MULTU.
- aluOut  in  WIDTH  ALU result.
- shiftOut  in  WIDTH  shifter result.
- op_ready  out  1  equals ~busy; op accepted only when op_valid && op_ready.
- busy  out  1  multiply in progress.
- dataOut  out  WIDTH  registered result.
- out_valid  out  1  one-cycle pulse: dataOut updated.
- mul_done  out  1  one-cycle pulse: HI/LO written.

Behaviour:
- Reset (reset==0, async):
  - State = IDLE.
  - dataOut, HI, LO, product, counter = 0.
  - out_valid, mul_done, busy = 0.
- States: IDLE, MUL.
- IDLE, accepted op, non-MULTU:
  - At the next edge, dataOut is loaded and out_valid=1 for one cycle (latency 1).
  - ALU codes load aluOut; SRL loads shiftOut; MFHI loads HI; MFLO loads LO.
  - Any other code loads 0, with out_valid still pulsed.
- IDLE, accepted MULTU:
  - Latch mcand = {WIDTH'b0, dataA} (2*WIDTH bits), mplier = dataB.
  - product = 0, count = 0, go to MUL.
  - busy=1 from this edge.
  - dataOut unchanged; no out_valid.
- MUL, each edge:
  - If mplier[0], product += mcand (2*WIDTH-bit, no overflow possible).
  - mcand <<= 1; mplier >>= 1; count++.
  - On the edge where count reaches WIDTH: {HI,LO} <= final product; state = IDLE; busy=0; mul_done=1 for one cycle.
- Multiply timing: busy high for exactly WIDTH cycles (32). HI/LO are visible to an MFHI/MFLO accepted on the first cycle busy==0.
- op_valid while busy: ignored, with no side effects. The bench must hold the op until op_ready.
- Outputs between ops:
  - dataOut holds its value while no op is accepted.
  - out_valid and mul_done are 0 except on their pulse cycle.
- HI/LO change only on mul_done or reset.
- Reset mid-multiply: immediate abort to IDLE with all registers cleared; no mul_done.
- out_valid and mul_done are never high in the same cycle, because ops are blocked while busy.

Optional Feature:
- MUL_EARLY_TERM_EN
- Defined:
  - In MUL, if the shifted mplier becomes 0 after an iteration, finish on that edge.
  - HI/LO = product, mul_done pulses, IDLE.
  - Latency = 1 + index of highest set bit of dataB, minimum 1 cycle.
  - dataB==0 finishes after 1 MUL cycle with HI=LO=0.
- Undefined: fixed WIDTH-cycle latency as above.
- Results are identical either way; only timing differs.

Test Plan:
- reset=0 mid-run, then release → all outputs 0, HI=LO=0; aluOut=0x12345678 with Signal=100000, op_valid=1 → next cycle dataOut=0x12345678, out_valid=1 for 1 cycle.
- Signal=SRL, shiftOut=0x0000F0F0, aluOut=0xDEADBEEF → dataOut=0x0000F0F0 one cycle later; unknown code 6'b111111 → dataOut=0, out_valid pulse.
- MULTU dataA=7, dataB=6 → busy 32 cycles, mul_done pulse; then MFLO → dataOut=0x0000002A and MFHI → dataOut=0.
- MULTU dataA=dataB=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; MFHI issued while busy is ignored (no out_valid) until op_ready=1.
- Reset asserted at cycle 10 of a multiply → busy=0 immediately, no mul_done, HI=LO=0.
- With MUL_EARLY_TERM_EN: MULTU dataA=5, dataB=3 → mul_done after 2 MUL cycles, LO=15; dataB=0 → done after 1 cycle, LO=0.
